// File: rtl/bcd_down_timer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | bcd_down_timer: NDIG-digit BCD down counter with one-shot/auto-reload,      |
// | borrow-chain terminal count and registered expiry pulse.  Rev 1.0           |
// +-----------------------------------------------------------------------------+
module bcd_down_timer #(
   parameter int NDIG = 2
) (
   input  logic              CLK,
   input  logic              CD,
   input  logic [4*NDIG-1:0] D,
   input  logic              LD,
   input  logic              EN,
   input  logic              AR,
   output logic [4*NDIG-1:0] Q,
   output logic              BUSY,
   output logic              TC,
   output logic              UF,
   output logic              ERR
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [4*NDIG-1:0] q_q, q_d;
   logic [4*NDIG-1:0] rld_q, rld_d;
   logic              uf_q, uf_d;
   logic              err_q, err_d;

   logic [4*NDIG-1:0] load_val;
   logic              load_bad;
   logic [4*NDIG-1:0] dec_val;
   logic              borrow;
   logic              q_zero;

   // Clamp out-of-range load digits to 9 so Q can never hold a non-BCD digit.
   always_comb begin
      load_val = D;
      load_bad = 1'b0;
      for (int k = 0; k < NDIG; k++) begin
         if (D[4*k +: 4] > 4'd9) begin
            load_val[4*k +: 4] = 4'd9;
            load_bad           = 1'b1;
         end
      end
   end

   always_comb begin
      dec_val = q_q;
      borrow  = 1'b1;
      for (int k = 0; k < NDIG; k++) begin
         if (borrow) begin
            if (q_q[4*k +: 4] == 4'd0) begin
               dec_val[4*k +: 4] = 4'd9;
            end else begin
               dec_val[4*k +: 4] = q_q[4*k +: 4] - 4'd1;
               borrow            = 1'b0;
            end
         end
      end
   end

   assign q_zero = (q_q == '0);

   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      rld_d   = rld_q;
      uf_d    = 1'b0;
      err_d   = err_q;
      if (LD) begin
         q_d     = load_val;
         rld_d   = load_val;
         err_d   = err_q | load_bad;
         state_d = ((load_val != '0) || AR) ? S_RUN : S_DONE;
      end else begin
         case (state_q)
            S_RUN: begin
               if (EN) begin
                  if (q_zero) begin
                     uf_d = 1'b1;
                     if (AR) begin
                        q_d = rld_q;
                     end else begin
                        state_d = S_DONE;
                     end
                  end else begin
                     q_d = dec_val;
                  end
               end
            end
            S_DONE: begin
               q_d = '0;
            end
            default: begin
               state_d = state_q;
            end
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (CD) begin
         state_q <= S_IDLE;
         q_q     <= '0;
         rld_q   <= '0;
         uf_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         rld_q   <= rld_d;
         uf_q    <= uf_d;
         err_q   <= err_d;
      end
   end

   assign Q    = q_q;
   assign BUSY = (state_q == S_RUN);
   assign TC   = q_zero && EN && (state_q == S_RUN);
   assign UF   = uf_q;
   assign ERR  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_down_timer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_bcd_down_timer: scoreboard bench for bcd_down_timer (NDIG=2, NDIG=3 and  |
// | a two-stage NDIG=1 cascade).  Rev 1.1                                       |
// +-----------------------------------------------------------------------------+
module tb_bcd_down_timer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // instance A: NDIG=2
    logic       cd_a = 1'b1, ld_a = 1'b0, en_a = 1'b0, ar_a = 1'b0;
    logic [7:0] d_a = '0, q_a;
    logic       busy_a, tc_a, uf_a, err_a;
    // instance B: NDIG=3
    logic        cd_b = 1'b1, ld_b = 1'b0, en_b = 1'b0, ar_b = 1'b0;
    logic [11:0] d_b = '0, q_b;
    logic        busy_b, tc_b, uf_b, err_b;
    // cascade: lower C (AR=1, D=9) drives EN of upper U (AR=0, D=2)
    logic       cd_c = 1'b1, ld_c = 1'b0, en_c = 1'b0;
    logic [3:0] q_c, q_u;
    logic       busy_c, tc_c, uf_c, err_c, busy_u, tc_u, uf_u, err_u;

    bcd_down_timer #(.NDIG(2)) u_a (
        .CLK(clk), .CD(cd_a), .D(d_a), .LD(ld_a), .EN(en_a), .AR(ar_a),
        .Q(q_a), .BUSY(busy_a), .TC(tc_a), .UF(uf_a), .ERR(err_a));

    bcd_down_timer #(.NDIG(3)) u_b (
        .CLK(clk), .CD(cd_b), .D(d_b), .LD(ld_b), .EN(en_b), .AR(ar_b),
        .Q(q_b), .BUSY(busy_b), .TC(tc_b), .UF(uf_b), .ERR(err_b));

    bcd_down_timer #(.NDIG(1)) u_c (
        .CLK(clk), .CD(cd_c), .D(4'h9), .LD(ld_c), .EN(en_c), .AR(1'b1),
        .Q(q_c), .BUSY(busy_c), .TC(tc_c), .UF(uf_c), .ERR(err_c));

    bcd_down_timer #(.NDIG(1)) u_u (
        .CLK(clk), .CD(cd_c), .D(4'h2), .LD(ld_c), .EN(tc_c), .AR(1'b0),
        .Q(q_u), .BUSY(busy_u), .TC(tc_u), .UF(uf_u), .ERR(err_u));

    typedef struct {
        int          inst;
        string       nm;
        logic [11:0] q;
        logic        busy;
        logic        uf;
        logic        err;
        logic        tc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [11:0] bcd(input int n);
        return {4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    // Apply one cycle of inputs to an instance and queue the state expected after the edge.
    task automatic cyc(input int inst, input logic cd, input logic ld, input logic en,
                       input logic ar, input logic [11:0] d, input logic [11:0] eq,
                       input logic eb, input logic eu, input logic ee, input string nm);
        exp_t e;
        logic zero;
        @(negedge clk);
        case (inst)
            0: begin cd_a = cd; ld_a = ld; en_a = en; ar_a = ar; d_a = d[7:0]; end
            1: begin cd_b = cd; ld_b = ld; en_b = en; ar_b = ar; d_b = d; end
            default: begin cd_c = cd; ld_c = ld; en_c = en; end
        endcase
        @(posedge clk);
        zero   = (inst == 2) ? (eq[3:0] == 4'h0) : (eq == 12'h0);
        e.inst = inst;
        e.nm   = nm;
        e.q    = eq;
        e.busy = eb;
        e.uf   = eu;
        e.err  = ee;
        e.tc   = zero && en && eb;
        sb.push_back(e);
    endtask

    // Monitor: inputs are still held at posedge+2, so TC reflects the applied EN.
    initial begin
        exp_t        e;
        logic [11:0] aq;
        logic        ab, au, ae, at;
        forever begin
            @(posedge clk);
            #2;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                case (e.inst)
                    0: begin aq = {4'h0, q_a}; ab = busy_a; au = uf_a; ae = err_a; at = tc_a; end
                    1: begin aq = q_b; ab = busy_b; au = uf_b; ae = err_b; at = tc_b; end
                    default: begin aq = {4'h0, q_u, q_c}; ab = busy_c; au = uf_c; ae = err_c; at = tc_c; end
                endcase
                total++;
                if ({aq, ab, au, ae, at} !== {e.q, e.busy, e.uf, e.err, e.tc}) begin
                    bad++;
                    $display("FAIL %s inst=%0d got q=%h busy=%b uf=%b err=%b tc=%b want q=%h busy=%b uf=%b err=%b tc=%b",
                             e.nm, e.inst, aq, ab, au, ae, at, e.q, e.busy, e.uf, e.err, e.tc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);

        // one-shot from 25 down to 00, then DONE
        cyc(0, 1, 0, 0, 0, 12'h0, 12'h0, 0, 0, 0, "reset");
        cyc(0, 0, 1, 1, 0, 12'h25, 12'h25, 1, 0, 0, "ld25");
        for (int n = 24; n >= 0; n--) cyc(0, 0, 0, 1, 0, 12'h0, bcd(n), 1, 0, 0, "down25");
        cyc(0, 0, 0, 1, 0, 12'h0, 12'h0, 0, 1, 0, "expire_oneshot");
        repeat (10) cyc(0, 0, 0, 1, 0, 12'h0, 12'h0, 0, 0, 0, "done_hold");

        // auto-reload from 03
        cyc(0, 0, 1, 1, 1, 12'h03, 12'h03, 1, 0, 0, "ld03_ar");
        for (int i = 1; i <= 12; i++)
            cyc(0, 0, 0, 1, 1, 12'h0, (i % 4 == 0) ? 12'h3 : 12'(3 - (i % 4)), 1,
                (i % 4 == 0), 0, "reload03");

        // clamp and sticky ERR
        cyc(0, 0, 1, 0, 1, 12'h1A, 12'h19, 1, 0, 1, "clamp1A");
        cyc(0, 0, 1, 0, 1, 12'h05, 12'h05, 1, 0, 1, "err_sticky");
        cyc(0, 1, 0, 0, 0, 12'h0, 12'h0, 0, 0, 0, "cd_clears_err");

        // simultaneous events
        cyc(0, 0, 1, 1, 1, 12'h02, 12'h02, 1, 0, 0, "ld02");
        cyc(0, 0, 0, 1, 1, 12'h0, 12'h01, 1, 0, 0, "dec01");
        cyc(0, 0, 0, 1, 1, 12'h0, 12'h00, 1, 0, 0, "dec00");
        cyc(0, 0, 1, 1, 1, 12'h07, 12'h07, 1, 0, 0, "ld_beats_expiry");
        cyc(0, 1, 1, 1, 1, 12'h55, 12'h0, 0, 0, 0, "cd_beats_ld");
        cyc(0, 0, 0, 1, 1, 12'h0, 12'h0, 0, 0, 0, "idle_ignores_en");

        // zero load: one-shot goes DONE, auto-reload divides by 1
        cyc(0, 0, 1, 1, 0, 12'h00, 12'h0, 0, 0, 0, "ld00_oneshot");
        repeat (3) cyc(0, 0, 0, 1, 0, 12'h0, 12'h0, 0, 0, 0, "ld00_no_uf");
        cyc(0, 0, 1, 0, 1, 12'h00, 12'h0, 1, 0, 0, "ld00_ar");
        repeat (3) cyc(0, 0, 0, 1, 1, 12'h0, 12'h0, 1, 1, 0, "div1");
        cyc(0, 0, 0, 0, 1, 12'h0, 12'h0, 1, 0, 0, "run_hold");

        // three-digit borrow chain
        cyc(1, 1, 0, 0, 0, 12'h0, 12'h0, 0, 0, 0, "reset3");
        cyc(1, 0, 1, 0, 0, 12'h100, 12'h100, 1, 0, 0, "ld100");
        cyc(1, 0, 0, 1, 0, 12'h0, 12'h099, 1, 0, 0, "borrow099");
        cyc(1, 0, 0, 0, 0, 12'h0, 12'h099, 1, 0, 0, "en0_hold");
        cyc(1, 0, 0, 1, 0, 12'h0, 12'h098, 1, 0, 0, "en1_098");
        cyc(1, 0, 1, 0, 0, 12'hFA5, 12'h995, 1, 0, 1, "clamp3");

        // cascade: upper stage steps once per ten lower-stage enables
        cyc(2, 1, 0, 0, 0, 12'h0, 12'h0, 0, 0, 0, "reset_casc");
        cyc(2, 0, 1, 0, 0, 12'h0, 12'h029, 1, 0, 0, "ld_casc");
        for (int k = 1; k <= 20; k++)
            cyc(2, 0, 0, 1, 0, 12'h0, {4'h0, 4'(2 - k / 10), 4'(9 - (k % 10))}, 1,
                (k % 10 == 0), 0, "cascade");
        cyc(2, 0, 0, 0, 0, 12'h0, 12'h009, 1, 0, 0, "casc_hold");

        @(posedge clk);
        #5;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard not drained: %0d entries left", sb.size());
        end
        if (total < 12) begin
            bad++;
            $display("FAIL too few checks executed: total=%0d", total);
        end
        if (bad != 0) begin
            $display("FAIL test done: total=%0d bad=%0d", total, bad);
        end else begin
            $display("PASS test done: total=%0d bad=%0d", total, bad);
        end
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bcd_down_timer.md
Name: bcd_down_timer

Overview:
- Multi-digit BCD down counter/timer. Complements the decade up counters in the macro library.
- Counts a loaded BCD value down to zero.
- At zero it either stops (one-shot) or reloads itself (auto-reload).
- Provides borrow-chain cascade outputs and an expiry pulse for timeout, prescale and refresh sequencing.

Parameters:
NDIG, 2, number of BCD digits; the counter is 4*NDIG bits wide and its maximum value is all nines.

Ports:
CLK  input  1  rising-edge clock.
CD  input  1  reset/clear; synchronous, active-high.
D  input  4*NDIG  parallel BCD load value; digit k occupies bits [4k+3:4k].
LD  input  1  parallel load strobe.
EN  input  1  count enable; one decrement per enabled cycle.
AR  input  1  auto-reload select: 1 = reload on expiry, 0 = one-shot.
Q  output  4*NDIG  current BCD count.
BUSY  output  1  high in state RUN.
TC  output  1  terminal count, combinational: (Q == 0) && EN && state RUN; used for cascading.
UF  output  1  registered one-cycle pulse on each expiry.
ERR  output  1  sticky invalid-digit load flag.

Behaviour:
- All state changes on the rising edge of CLK. Priority is CD > LD > EN.
- Reset (CD=1):
  - Q=0, RLD register=0, state IDLE.
  - BUSY=0, UF=0, ERR=0.
  - Takes effect on the next edge regardless of the current state (mid-count included).
- Load (LD=1):
  - D is sanitised per digit: any digit >9 is clamped to 9, and ERR is set (sticky until CD).
  - The sanitised value is written to both Q and RLD.
  - State becomes RUN if the sanitised value is nonzero.
  - If the value is zero: AR=1 gives RUN, AR=0 gives DONE.
  - LD has priority over EN in the same cycle; no decrement occurs.
  - UF=0 in the load cycle.
- States:
  - IDLE: Q holds; EN ignored. Exit only via LD.
  - RUN, EN=1, Q != 0: BCD decrement.
    - Digit 0 decrements.
    - A digit at 0 becomes 9 and borrows into the next digit.
    - Latency is 1 cycle from EN to the new Q.
  - RUN, EN=1, Q == 0 (expiry):
    - UF=1 on the next cycle, for exactly one cycle.
    - If AR=1: Q<=RLD, stay in RUN.
    - If AR=0: Q stays 0, go to DONE.
  - RUN, EN=0: hold; UF=0.
  - DONE: Q=0 held, BUSY=0, EN ignored. Exit via LD or CD.
- AR is sampled at the expiry edge and at LD. Changing AR at other times has no effect on an in-progress count.
- Auto-reload with RLD=0: Q stays 0 and UF pulses once per enabled cycle, giving a divide-by-1 rate.
- Period: with AR=1 and RLD=N, UF asserts once every N+1 enabled cycles.
- Cascading: the TC of a lower stage drives the EN of the next stage.
- Q never holds a non-BCD digit under any input sequence.

Test Plan:
- Reset, then LD with D=8'h25, AR=0, EN=1 continuous:
  - Q follows 25,24,...,20,19,...,01,00.
  - UF pulses once, one cycle after the Q=00 enabled cycle.
  - State goes to DONE; BUSY=0; Q stays 00 for 10 more cycles.
- LD with D=8'h03, AR=1, EN=1 for 12 cycles:
  - Q sequence is 03,02,01,00,03,02,...
  - UF pulses every 4th cycle, 3 pulses in total; BUSY stays 1.
- LD with D=8'h1A:
  - Q=19 and ERR=1.
  - A later LD with 8'h05 leaves ERR=1.
  - CD clears ERR to 0.
- Simultaneous events:
  - LD=1 with EN=1 and Q=00 in RUN: Q=D and UF=0, so load beats expiry.
  - CD=1 with LD=1: Q=00 and state IDLE.
- Borrow chain, NDIG=3:
  - LD with 12'h100, then one EN gives Q=099.
  - EN toggled 1,0,1 over three cycles: Q goes 099, 099, 098.
- Cascade:
  - Two NDIG=1 instances with TC0 driving EN1; lower stage AR=1, D=9; upper stage D=2.
  - The upper stage decrements once per 10 enabled cycles of the lower stage.
- AR=0 with D=00: state DONE immediately and UF never asserts.
